// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial operands into an external
// comparator and recovers the hidden operand MSB first from lt/eq/gt verdicts.
module sar_search_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         cmp_lt,
    input  logic                         cmp_eq,
    input  logic                         cmp_gt,
    output logic [WIDTH-1:0]             trial,
    output logic [WIDTH-1:0]             result,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(WIDTH+1)-1:0]   steps
);

    localparam int unsigned SW = $clog2(WIDTH + 1);
    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {StIdle, StWait, StEval, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [SW-1:0]    steps_q, steps_d;
    logic [WIDTH-1:0] upd_acc;
    logic             verdict_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            trial_q   <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            steps_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            trial_q   <= trial_d;
            result_q  <= result_d;
            err_q     <= err_d;
            steps_q   <= steps_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        trial_d   = trial_q;
        result_d  = result_q;
        err_d     = err_q;
        steps_d   = steps_q;
        // Exactly one verdict flag must be set for the evaluation to be trusted.
        verdict_ok = (cmp_lt ^ cmp_eq ^ cmp_gt) & ~(cmp_lt & cmp_eq & cmp_gt);
        upd_acc    = cmp_lt ? trial_q : acc_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d     = '0;
                    bit_idx_d = BW'(WIDTH - 1);
                    trial_d   = WIDTH'(1) << (WIDTH - 1);
                    cnt_d     = CW'(SETTLE);
                    steps_d   = '0;
                    err_d     = 1'b0;
                    result_d  = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (cnt_q == CW'(1)) begin
                    state_d = StEval;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StEval: begin
                steps_d = steps_q + SW'(1);
                state_d = StDone;
                if (!verdict_ok) begin
                    err_d    = 1'b1;
                    result_d = acc_q;
                end else if (cmp_eq) begin
                    result_d = trial_q;
                end else begin
                    acc_d = upd_acc;
                    if (bit_idx_q == '0) begin
                        result_d = upd_acc;
                    end else begin
                        bit_idx_d = bit_idx_q - BW'(1);
                        trial_d   = upd_acc | (WIDTH'(1) << (bit_idx_q - BW'(1)));
                        cnt_d     = CW'(SETTLE);
                        state_d   = StWait;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign trial  = trial_q;
    assign result = result_q;
    assign err    = err_q;
    assign steps  = steps_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench: two controllers (SETTLE=1 and SETTLE=3) each searching a hidden value
// through a behavioural comparator, checked against a binary-search reference model.
module tb_sar_search_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic [3:0] hidden1 = '0, hidden3 = '0;
    logic       force_en = 1'b0;
    logic [2:0] force_flags = '0;  // {lt, eq, gt}

    logic [3:0] trial1, result1, trial3, result3;
    logic       busy1, done1, err1, busy3, done3, err3;
    logic [2:0] steps1, steps3;
    logic       lt1, eq1, gt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign lt1 = force_en ? force_flags[2] : (trial1 < hidden1);
    assign eq1 = force_en ? force_flags[1] : (trial1 == hidden1);
    assign gt1 = force_en ? force_flags[0] : (trial1 > hidden1);

    sar_search_ctrl #(.WIDTH(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .cmp_lt(lt1), .cmp_eq(eq1), .cmp_gt(gt1),
        .trial(trial1), .result(result1), .busy(busy1), .done(done1),
        .err(err1), .steps(steps1)
    );

    sar_search_ctrl #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .cmp_lt(trial3 < hidden3), .cmp_eq(trial3 == hidden3), .cmp_gt(trial3 > hidden3),
        .trial(trial3), .result(result3), .busy(busy3), .done(done3),
        .err(err3), .steps(steps3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic get_view(input bit sel, output logic [3:0] t, output logic [3:0] r,
                            output logic b, output logic d, output logic e,
                            output logic [2:0] s);
        if (sel) begin
            t = trial3; r = result3; b = busy3; d = done3; e = err3; s = steps3;
        end else begin
            t = trial1; r = result1; b = busy1; d = done1; e = err1; s = steps1;
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start3 = v;
        else start1 = v;
    endtask

    // Runs one search; forced=1 means the comparator answers force_flags (invalid verdict).
    task automatic run_search(input bit sel, input logic [3:0] h, input bit forced,
                              input bit poke_start);
        int         settle = sel ? 3 : 1;
        logic [3:0] exp_trials[$];
        logic [3:0] acc = 4'd0;
        logic [3:0] exp_result;
        int         exp_steps;
        bit         exp_err;
        int         c;
        int         done_c = -1;
        logic [3:0] t, r;
        logic       b, d, e;
        logic [2:0] s;

        if (forced) begin
            exp_trials.push_back(4'b1000);
            exp_result = 4'd0;
            exp_steps  = 1;
            exp_err    = 1'b1;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                logic [3:0] cand = acc | 4'(1 << i);
                exp_trials.push_back(cand);
                if (cand == h) break;
                if (cand < h) acc = cand;
            end
            exp_result = h;
            exp_steps  = exp_trials.size();
            exp_err    = 1'b0;
        end

        if (sel) hidden3 = h;
        else hidden1 = h;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        get_view(sel, t, r, b, d, e, s);
        check("busy_after_start", 32'(b), 32'd1);

        for (c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clk);
            get_view(sel, t, r, b, d, e, s);
            if ((c % (settle + 1)) == 0 && (c / (settle + 1)) < exp_steps)
                check("trial_seq", 32'(t), 32'(exp_trials[c / (settle + 1)]));
            if (poke_start && c == 2) set_start(sel, 1'b1);
            if (poke_start && c == 3) set_start(sel, 1'b0);
            if (d) begin
                done_c = c;
                break;
            end
        end
        check("done_cycle", 32'(done_c), 32'(exp_steps * (settle + 1)));
        check("result", 32'(r), 32'(exp_result));
        check("steps", 32'(s), 32'(exp_steps));
        check("err", 32'(e), 32'(exp_err));
        check("busy_in_done", 32'(b), 32'd1);
        @(negedge clk);
        get_view(sel, t, r, b, d, e, s);
        check("done_pulse_end", 32'(d), 32'd0);
        check("busy_after_done", 32'(b), 32'd0);
        check("result_held", 32'(r), 32'(exp_result));
        if (!forced) check("trial_held", 32'(t), 32'(exp_trials[exp_steps - 1]));
    endtask

    initial begin
        #1;
        check("rst_trial", 32'(trial1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        check("rst_steps", 32'(steps1), 32'd0);
        check("rst_result", 32'(result1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_search(1'b0, 4'b1011, 1'b0, 1'b0);
        run_search(1'b0, 4'b1000, 1'b0, 1'b0);
        run_search(1'b0, 4'b0000, 1'b0, 1'b0);
        run_search(1'b0, 4'b1111, 1'b0, 1'b0);

        force_en = 1'b1;
        force_flags = 3'b000;
        run_search(1'b0, 4'b0110, 1'b1, 1'b0);
        force_flags = 3'b110;
        run_search(1'b0, 4'b0110, 1'b1, 1'b0);
        force_en = 1'b0;
        run_search(1'b0, 4'b0110, 1'b0, 1'b0);

        run_search(1'b1, 4'b0110, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_search(1'b0, 4'($urandom_range(15)), 1'b0, 1'b0);
            run_search(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0);
        end

        // Reset in the middle of a search, after the second evaluation.
        hidden1 = 4'b0011;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_trial", 32'(trial1), 32'd0);
        check("mid_rst_busy", 32'(busy1), 32'd0);
        check("mid_rst_done", 32'(done1), 32'd0);
        check("mid_rst_steps", 32'(steps1), 32'd0);
        check("mid_rst_result", 32'(result1), 32'd0);
        check("mid_rst_err", 32'(err1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_search(1'b0, 4'b0101, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
